add_acc_pipe: RTL

Parametrised successor to the 4-bit registered adder. Two-stage pipelined adder with valid tagging and two modes: pairwise add with carry-out, or accumulation of ACC_LEN consecutive a+b results into one widened sum. Sits between the tap-product stage and the output register of the 1D convolution datapath, where it sums partial products across taps.

---
 rtl/add_acc_pipe.sv | 99 +++++++++
 1 files changed

// File: rtl/add_acc_pipe.sv
// add_acc_pipe: two-stage pipelined unsigned adder with valid tagging.
//   mode 0: pairwise a+b, result on sum/cout with a one-cycle out_valid pulse.
//   mode 1: ACC_LEN consecutive a+b results are summed into acc_out,
//           with a one-cycle acc_valid pulse per completed window.
// Ports:
//   ck, rst_n            clock (rising edge), async active-low reset
//   in_valid, a, b, mode input sample and its mode
//   clr                  synchronous accumulator/window clear (stage 2)
//   out_valid, sum, cout pairwise result
//   acc_valid, acc_out   window total
//   busy                 a partial window is held
module add_acc_pipe #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned ACC_LEN = 3,
  localparam int unsigned ACC_W  = WIDTH + 1 + $clog2(ACC_LEN)
) (
  input  logic             ck,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             acc_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic             busy
);

  localparam int unsigned PW    = WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(ACC_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

  logic [PW-1:0]    p;
  logic             p_valid;
  logic             p_mode;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  // Stage 1: register the raw sum with its valid and mode tags.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      p       <= '0;
      p_valid <= 1'b0;
      p_mode  <= 1'b0;
    end else begin
      p       <= PW'(a) + PW'(b);
      p_valid <= in_valid;
      p_mode  <= mode;
    end
  end

  // Stage 2: pairwise output path, independent of the accumulator.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (p_valid && !p_mode) begin
        {cout, sum} <= p;
        out_valid   <= 1'b1;
      end
    end
  end

  // Stage 2: accumulation window; clr wins and discards a coincident
  // mode-1 sample.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (p_valid && p_mode) begin
        if (cnt == LAST) begin
          acc_out   <= acc + ACC_W'(p);
          acc_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= acc + ACC_W'(p);
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign busy = (cnt != '0);

endmodule
